// File: rtl/alu_multicycle_pkg.sv
// alu_multicycle_pkg: shared ALU opcode encoding (also used by the decoder)
// and the shift-step kinds.
package alu_multicycle_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [1:0] {SH_LEFT, SH_SRL, SH_SRA} shift_kind_e;

    function automatic logic is_shift(input logic [3:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: shifts a word by one bit position (left, logical right,
// or arithmetic right).
module alu_shift_step
    import alu_multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] d_i,
    input  shift_kind_e     kind_i,
    output logic [XLEN-1:0] q_o
);
    assign q_o = kind_i == SH_LEFT ? {d_i[XLEN-2:0], 1'b0}
                                   : {kind_i == SH_SRA && d_i[XLEN-1], d_i[XLEN-1:1]};
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU; single-cycle ops finish at once, shifts
// iterate one bit per cycle through alu_shift_step.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] res_q, res_d, alu_res, step_res;
    logic [4:0]      cnt_q, cnt_d;
    logic            ill_q, ill_d;
    logic [4:0]      shamt;
    shift_kind_e     kind;

    assign shamt = op_b[4:0];

    // Shifts load op_a here and then iterate; a zero shamt finishes as-is.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:                   alu_res = op_a + op_b;
            ALU_SUB:                   alu_res = op_a - op_b;
            ALU_SLT:                   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:                  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:                   alu_res = op_a ^ op_b;
            ALU_OR:                    alu_res = op_a | op_b;
            ALU_AND:                   alu_res = op_a & op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
            default:                   alu_res = '0;
        endcase
    end

    assign kind = op_q == ALU_SLL ? SH_LEFT : op_q == ALU_SRA ? SH_SRA : SH_SRL;

    alu_shift_step #(.XLEN(XLEN)) u_step (
        .d_i    (res_q),
        .kind_i (kind),
        .q_o    (step_res)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = alu_op;
                res_d   = alu_res;
                ill_d   = alu_op > ALU_AND;
                cnt_d   = shamt;
                state_d = is_shift(alu_op) && shamt != 5'd0 ? SHIFT : DONE;
            end
            SHIFT: begin
                res_d   = step_res;
                cnt_d   = cnt_q - 5'd1;
                state_d = cnt_q == 5'd1 ? DONE : SHIFT;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign result     = res_q;
    assign zero       = out_valid && res_q == '0;
    assign illegal_op = out_valid && ill_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random transactions checked against an
// arithmetic reference model of the ALU.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    alu_multicycle #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {illegal, result}
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh;
        sh = b[4:0];
        r = '0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << sh;
            4'd3: r = {31'b0, $signed(a) < $signed(b)};
            4'd4: r = {31'b0, a < b};
            4'd5: r = a ^ b;
            4'd6: r = a >> sh;
            4'd7: r = $signed(a) >>> sh;
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: return {1'b1, 32'b0};
        endcase
        return {1'b0, r};
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        return (op == 4'd2 || op == 4'd6 || op == 4'd7) ? int'(b[4:0]) + 1 : 1;
    endfunction

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output logic [31:0] r_o, output int lat_o);
        logic [32:0] m;
        int w;
        m = ref_alu(op, a, b);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        alu_op = op;
        op_a = a;
        op_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        alu_op = 4'($urandom);
        op_a = $urandom;
        op_b = $urandom;
        lat_o = 1;
        while (!out_valid && lat_o < 40) begin
            @(negedge clk);
            lat_o++;
        end
        r_o = result;
        check("latency", lat_o, ref_lat(op, b));
        check("result", result, m[31:0]);
        check("zero", zero, m[31:0] == 32'd0);
        check("illegal", illegal_op, m[32]);
        check("busy_ready", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, m[31:0]);
            check("hold_zero", zero, m[31:0] == 32'd0);
            check("hold_illegal", illegal_op, m[32]);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    function automatic logic [31:0] pick(input int sel);
        return sel == 0 ? 32'h0 : sel == 1 ? 32'hFFFF_FFFF : sel == 2 ? 32'h8000_0000 : $urandom;
    endfunction

    initial begin
        logic [31:0] r;
        int lat;
        bit seen;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_illegal", illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        run(4'd0, 32'hFFFF_FFFF, 32'h1, 0, r, lat);
        check("add_wrap", r, 32'h0);
        check("add_lat", lat, 1);
        run(4'd3, 32'hFFFF_FFFF, 32'h1, 1, r, lat);
        check("slt", r, 32'h1);
        run(4'd4, 32'hFFFF_FFFF, 32'h1, 0, r, lat);
        check("sltu", r, 32'h0);
        run(4'd7, 32'h8000_0000, 32'd4, 2, r, lat);
        check("sra", r, 32'hF800_0000);
        check("sra_lat", lat, 5);
        run(4'd6, 32'h8000_0000, 32'd4, 0, r, lat);
        check("srl", r, 32'h0800_0000);
        run(4'd2, 32'h1, 32'd0, 0, r, lat);
        check("sll0", r, 32'h1);
        check("sll0_lat", lat, 1);
        run(4'd2, 32'h1, 32'd31, 0, r, lat);
        check("sll31", r, 32'h8000_0000);
        check("sll31_lat", lat, 32);
        run(4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 3, r, lat);
        check("illegal_res", r, 32'h0);

        // reset while shifting: SLL by 20, pulled at cycle 10
        in_valid = 1'b1;
        alu_op = 4'd2;
        op_a = 32'h3;
        op_b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", in_ready, 1);
        check("midrst_valid", out_valid, 0);
        check("midrst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("midrst_no_valid", seen, 0);
        run(4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, r, lat);
        check("post_rst_xor", r, 32'hFF00_FF00);

        for (int k = 0; k < 150; k++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = pick($urandom_range(0, 3));
            b = pick($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) b[31:5] = '0;
            run(op, a, b, $urandom_range(0, 3), r, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width in bits.
REQ-002 Port: clk, input, 1, rising-edge clock; sole clock domain.
REQ-003 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: in_valid, input, 1, operation request present.
REQ-005 Port: in_ready, output, 1, block can accept a request.
REQ-006 Port: alu_op, input, 4, operation code from the instruction decoder.
REQ-007 Port: op_a, input, XLEN, first operand.
REQ-008 Port: op_b, input, XLEN, second operand; shift amount is op_b[4:0].
REQ-009 Port: out_valid, output, 1, result present.
REQ-010 Port: out_ready, input, 1, consumer accepts the result.
REQ-011 Port: result, output, XLEN, operation result.
REQ-012 Port: zero, output, 1, result == 0.
REQ-013 Port: illegal_op, output, 1, alu_op not in the defined encoding; qualified by out_valid.

Function
REQ-014 States SHALL be IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge with in_valid && in_ready.
REQ-016 Operand and alu_op values SHALL be captured at acceptance; later input changes SHALL not affect the result.
REQ-017 Encoding: ALUAdd=0, ALUSub=1, ALUSLL=2, ALUSLT=3, ALUSLTU=4, ALUXOR=5, ALUSRL=6, ALUSRA=7, ALUOR=8, ALUAND=9; codes 10-15 illegal.
REQ-018 ADD/SUB SHALL wrap modulo 2^XLEN; SLT signed and SLTU unsigned compare yield 1 or 0 zero-extended.
REQ-019 Non-shift ops and illegal codes: IDLE -> DONE on acceptance; out_valid asserted the cycle after acceptance (latency 1).
REQ-020 Illegal code: result = 0, zero = 1, illegal_op = 1.
REQ-021 Shifts with shamt != 0: IDLE -> SHIFT; one bit position per cycle; SHIFT -> DONE after shamt iterations; out_valid asserted shamt+1 cycles after acceptance.
REQ-022 Shifts with shamt == 0: IDLE -> DONE directly, result = op_a, latency 1.
REQ-023 SRA SHALL replicate op_a[XLEN-1] into vacated bits; SRL and SLL fill with 0.
REQ-024 In DONE, result, zero, illegal_op SHALL be held stable while out_valid=1 && out_ready=0.
REQ-025 DONE -> IDLE on out_valid && out_ready; no new request accepted in that same cycle (in_ready rises the following cycle).
REQ-026 out_ready SHALL be ignored outside DONE; in_valid ignored outside IDLE.

Reset
REQ-027 On rst_n=0, state SHALL go to IDLE immediately, independent of clk.
REQ-028 Reset values: in_ready=1 after release (0 while asserted not required), out_valid=0, result=0, zero=0, illegal_op=0, shift counter=0.
REQ-029 Reset during SHIFT or DONE SHALL discard the in-flight operation with no out_valid pulse.

Structure
REQ-030 The alu_op encoding constants SHALL live in the shared params package alongside the decoder, so decoder and ALU share one definition.
REQ-031 State encoding typedef SHALL be local to the module.
REQ-032 One sub-module, alu_shift_step, SHALL implement a single-bit shift step (left, logical right, arithmetic right); all other logic inline.

Verification
REQ-033 ADD 0xFFFFFFFF + 0x00000001 -> result 0, zero=1, out_valid one cycle after acceptance.
REQ-034 SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU same operands -> 0.
REQ-035 SRA 0x80000000 by 4 -> 0xF8000000, out_valid exactly 5 cycles after acceptance; SRL same -> 0x08000000.
REQ-036 SLL 0x1 by 0 -> 0x1 at latency 1; SLL 0x1 by 31 -> 0x80000000 at latency 32.
REQ-037 alu_op=4'hC -> illegal_op=1, result 0; out_ready held low 3 cycles -> outputs stable, in_ready=0 throughout.
REQ-038 rst_n pulsed low mid-SHIFT (SLL by 20, cycle 10) -> immediate IDLE, out_valid never asserted, next request processed normally.
